// File: rtl/xs3_digit_accumulator.sv
// xs3_digit_accumulator
//   Packs a most-significant-first stream of decoded decimal digits (from the
//   excess-3 -> binary digit converter) into one binary integer,
//   acc = acc*10 + digit. The finished number is offered on a valid/ready port
//   together with a sticky error flag and the number of digits consumed.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   in_valid   digit/digit_err/last are valid
//   in_ready   block accepts a digit this cycle
//   digit      decoded digit, legal 0..9
//   digit_err  upstream decode error for this digit
//   last       this digit ends the number
//   out_valid  value/out_err/dig_count are valid
//   out_ready  consumer takes the result
//   value      accumulated integer (reads 0 while accumulating)
//   out_err    bad digit or overflow seen in this number
//   dig_count  digits accepted for this number
//
// state | meaning
// ACC   | accepting digits, result outputs forced to 0
// DONE  | result presented and held until out_ready

module xs3_digit_accumulator #(
  parameter int NDIG = 4,
  parameter int OUTW = 14,
  parameter int CNTW = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      digit,
  input  logic            digit_err,
  input  logic            last,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [OUTW-1:0] value,
  output logic            out_err,
  output logic [CNTW-1:0] dig_count
);

  typedef enum logic {ACC = 1'b0, DONE = 1'b1} state_t;

  localparam logic [OUTW+3:0] TEN     = (OUTW+4)'(10);
  localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);
  localparam logic [CNTW-1:0] CNT_LIM = CNTW'(NDIG);

  state_t            state, state_nxt;
  logic [OUTW-1:0]   acc, acc_nxt;
  logic              err, err_nxt;
  logic [CNTW-1:0]   cnt, cnt_nxt;

  logic              bad;
  logic [3:0]        eff;
  logic [OUTW+3:0]   prod;
  logic [CNTW-1:0]   cnt_inc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ACC;
      acc   <= '0;
      err   <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      err   <= err_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    // Bad digits contribute 0 so the position weighting of later digits holds.
    bad       = digit_err | (digit > 4'd9);
    eff       = bad ? 4'd0 : digit;
    // Four guard bits catch the carry out of acc*10 + eff.
    prod      = ({4'd0, acc} * TEN) + {{OUTW{1'b0}}, eff};
    cnt_inc   = cnt + CNT_ONE;

    state_nxt = state;
    acc_nxt   = acc;
    err_nxt   = err;
    cnt_nxt   = cnt;

    in_ready  = 1'b0;
    out_valid = 1'b0;
    value     = '0;
    out_err   = 1'b0;
    dig_count = '0;

    case (state)
      ACC: begin
        in_ready = 1'b1;
        if (in_valid) begin
          acc_nxt = prod[OUTW-1:0];
          err_nxt = err | bad | (|prod[OUTW+3:OUTW]);
          cnt_nxt = cnt_inc;
          if (last || (cnt_inc == CNT_LIM)) state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        value     = acc;
        out_err   = err;
        dig_count = cnt;
        if (out_ready) begin
          state_nxt = ACC;
          acc_nxt   = '0;
          err_nxt   = 1'b0;
          cnt_nxt   = '0;
        end
      end
      default: state_nxt = ACC;
    endcase
  end

endmodule

// File: tb/tb_xs3_digit_accumulator.sv
// Bench for xs3_digit_accumulator: directed scenarios followed by random
// traffic, every cycle compared against a digit-list reference model.

module tb_xs3_digit_accumulator;

  localparam int NDIG = 4;
  localparam int OUTW = 14;
  localparam int CNTW = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      digit;
  logic            digit_err;
  logic            last;
  logic            out_valid;
  logic            out_ready;
  logic [OUTW-1:0] value;
  logic            out_err;
  logic [CNTW-1:0] dig_count;

  int checks = 0;
  int errors = 0;

  // reference model: digits of the number in progress, and whether done
  int q_dig[$];
  bit q_bad[$];
  bit m_done;

  always #5 clk = ~clk;

  xs3_digit_accumulator #(.NDIG(NDIG), .OUTW(OUTW), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .digit(digit), .digit_err(digit_err), .last(last),
    .out_valid(out_valid), .out_ready(out_ready), .value(value),
    .out_err(out_err), .dig_count(dig_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Decimal value of the digit list, wrapped to OUTW bits, plus error status.
  task automatic model_result(output int v, output bit e);
    longint n;
    v = 0;
    e = 0;
    for (int i = 0; i < q_dig.size(); i++) begin
      n = longint'(v) * 10 + (q_bad[i] ? 0 : q_dig[i]);
      if (n >= (longint'(1) << OUTW)) e = 1;
      v = int'(n % (longint'(1) << OUTW));
      e = e | q_bad[i];
    end
  endtask

  task automatic cyc(input bit r, input bit iv, input int d, input bit de,
                     input bit l, input bit ordy);
    int  v;
    bit  e;
    rst = r; in_valid = iv; digit = 4'(d); digit_err = de; last = l; out_ready = ordy;
    @(posedge clk);
    #1;
    if (r) begin
      q_dig.delete(); q_bad.delete(); m_done = 0;
    end else if (m_done) begin
      if (ordy) begin
        q_dig.delete(); q_bad.delete(); m_done = 0;
      end
    end else if (iv) begin
      q_dig.push_back(d);
      q_bad.push_back(de || (d > 9));
      if (l || q_dig.size() == NDIG) m_done = 1;
    end
    model_result(v, e);
    chk("in_ready",  32'(in_ready),  32'(!m_done));
    chk("out_valid", 32'(out_valid), 32'(m_done));
    chk("value",     32'(value),     m_done ? 32'(v) : 32'd0);
    chk("out_err",   32'(out_err),   m_done ? 32'(e) : 32'd0);
    chk("dig_count", 32'(dig_count), m_done ? 32'(q_dig.size()) : 32'd0);
  endtask

  initial begin
    m_done = 0;

    // T1: reset state, then 1234
    cyc(1, 0, 0, 0, 0, 1);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_value", 32'(value), 32'd0);
    cyc(0, 1, 1, 0, 0, 1);
    cyc(0, 1, 2, 0, 0, 1);
    cyc(0, 1, 3, 0, 0, 1);
    cyc(0, 1, 4, 0, 1, 1);
    chk("t1_valid", 32'(out_valid), 32'd1);
    chk("t1_value", 32'(value), 32'd1234);
    chk("t1_err", 32'(out_err), 32'd0);
    chk("t1_cnt", 32'(dig_count), 32'd4);

    // T2: 42 then 7 with a single bubble (digit 4 offered in the DONE cycle)
    cyc(0, 1, 4, 0, 0, 1);
    chk("t1_bubble", 32'(in_ready), 32'd1);
    cyc(0, 1, 4, 0, 0, 1);
    cyc(0, 1, 2, 0, 1, 1);
    chk("t2_value_a", 32'(value), 32'd42);
    chk("t2_cnt_a", 32'(dig_count), 32'd2);
    chk("t2_bubble", 32'(in_ready), 32'd0);
    cyc(0, 1, 7, 0, 1, 1);
    chk("t2_ready_back", 32'(in_ready), 32'd1);
    cyc(0, 1, 7, 0, 1, 1);
    chk("t2_value_b", 32'(value), 32'd7);
    chk("t2_cnt_b", 32'(dig_count), 32'd1);

    // T3: bad digit zeroed, sticky error cleared for next number
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 1, 5, 0, 0, 1);
    cyc(0, 1, 3, 1, 0, 1);
    cyc(0, 1, 6, 0, 1, 1);
    chk("t3_value", 32'(value), 32'd506);
    chk("t3_err", 32'(out_err), 32'd1);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 1, 8, 0, 1, 1);
    chk("t3_err_clr", 32'(out_err), 32'd0);
    chk("t3_value2", 32'(value), 32'd8);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 1, 12, 0, 1, 1);
    chk("t3_gt9_err", 32'(out_err), 32'd1);
    cyc(0, 0, 0, 0, 0, 1);

    // T4 + T5: auto-terminate at NDIG, then hold with 5th digit pending
    for (int i = 0; i < 4; i++) cyc(0, 1, 9, 0, 0, 0);
    chk("t4_value", 32'(value), 32'd9999);
    chk("t4_err", 32'(out_err), 32'd0);
    for (int i = 0; i < 10; i++) begin
      cyc(0, 1, 5, 0, 1, 0);
      chk("t5_hold", 32'(value), 32'd9999);
    end
    cyc(0, 1, 5, 0, 1, 1);
    chk("t5_release", 32'(in_ready), 32'd1);
    cyc(0, 1, 5, 0, 1, 1);
    chk("t4_fifth", 32'(value), 32'd5);
    cyc(0, 0, 0, 0, 0, 1);

    // T6: reset mid-number discards it
    cyc(0, 1, 3, 0, 0, 1);
    cyc(0, 1, 1, 0, 0, 1);
    cyc(1, 1, 9, 0, 1, 1);
    chk("t6_no_result", 32'(out_valid), 32'd0);
    cyc(0, 1, 2, 0, 1, 1);
    chk("t6_value", 32'(value), 32'd2);
    chk("t6_cnt", 32'(dig_count), 32'd1);
    cyc(1, 0, 0, 0, 0, 0);

    // random traffic against the model
    for (int i = 0; i < 600; i++) begin
      cyc($urandom_range(0, 99) < 2,
          $urandom_range(0, 99) < 75,
          ($urandom_range(0, 9) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9),
          $urandom_range(0, 99) < 8,
          $urandom_range(0, 99) < 30,
          $urandom_range(0, 99) < 65);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
